// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: shares one text-buffer write port between CPU stores and a
// register-dump engine. The engine reads DUMP_ROWS registers via the debug port
// and writes each register as 8 hex characters at row*COLS+col.
// Write port output is registered: the winner of cycle N appears on vga_* after edge N.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   i_cpu_req/addr/data      CPU store request, held until o_cpu_gnt
//   o_cpu_gnt                one-cycle pulse alongside the CPU's vga write
//   i_dump_start             pulse; starts a dump when idle
//   o_dump_busy, o_dump_done dump in progress / one-cycle completion pulse
//   o_dbg_reg_addr           register index to the register file debug port
//   i_dbg_reg_data           combinational debug read data
//   o_vga_we/addr/data       text-buffer write port
//
// WORD_SIZE must be at least 32.
// Optional feature: define VGA_WRITE_ARB_ROUND_ROBIN_EN for round-robin arbitration
// on contested cycles. Otherwise the CPU has fixed priority.
module vga_write_arbiter #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned DUMP_ROWS = 32,
  parameter int unsigned COLS      = 80
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cpu_req,
  input  logic [12:0]          i_cpu_addr,
  input  logic [WORD_SIZE-1:0] i_cpu_data,
  output logic                 o_cpu_gnt,
  input  logic                 i_dump_start,
  output logic                 o_dump_busy,
  output logic                 o_dump_done,
  output logic [4:0]           o_dbg_reg_addr,
  input  logic [WORD_SIZE-1:0] i_dbg_reg_data,
  output logic                 o_vga_we,
  output logic [12:0]          o_vga_addr,
  output logic [WORD_SIZE-1:0] o_vga_data
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR    = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_EMIT    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [4:0]  LAST_ROW = 5'(DUMP_ROWS - 1);
  localparam logic [12:0] COLS_W   = 13'(COLS);

  logic [2:0]           r_state, w_state_n;
  logic [4:0]           r_row, w_row_n;
  logic [2:0]           r_col, w_col_n;
  logic [31:0]          r_shadow;
  logic                 r_cpu_gnt;
  logic                 r_dump_done;
  logic                 r_vga_we;
  logic [12:0]          r_vga_addr;
  logic [WORD_SIZE-1:0] r_vga_data;

  logic                 w_dump_req;
  logic                 w_cpu_elig;
  logic                 w_cpu_win;
  logic                 w_dump_win;
  logic [3:0]           w_nib;
  logic [7:0]           w_ascii;
  logic [12:0]          w_dump_addr;
  logic [WORD_SIZE-1:0] w_dump_data;

  assign w_dump_req = (r_state == ST_EMIT);
  // A request still high in its grant cycle is the same store; do not take it again.
  assign w_cpu_elig = i_cpu_req & ~r_cpu_gnt;

`ifdef VGA_WRITE_ARB_ROUND_ROBIN_EN
  // Set when the dump has priority on the next contested cycle.
  logic r_prio_dump;
  assign w_cpu_win = w_cpu_elig & (~w_dump_req | ~r_prio_dump);
`else
  assign w_cpu_win = w_cpu_elig;
`endif
  assign w_dump_win = w_dump_req & ~w_cpu_win;

  // Most-significant nibble first: col 0 selects bits [31:28], i.e. index 4*(7-col).
  assign w_nib   = r_shadow[{~r_col, 2'b00} +: 4];
  assign w_ascii = (w_nib < 4'd10) ? (8'h30 + {4'd0, w_nib}) : (8'h37 + {4'd0, w_nib});
  // 13-bit arithmetic gives the truncated address directly.
  assign w_dump_addr = r_row * COLS_W + {10'd0, r_col};

  always_comb begin
    w_dump_data       = '0;
    w_dump_data[31:0] = {w_ascii, 24'hFFFFFF};
  end

  always_comb begin
    w_state_n = r_state;
    w_row_n   = r_row;
    w_col_n   = r_col;
    case (r_state)
      ST_IDLE: begin
        if (i_dump_start) begin
          w_state_n = ST_ADDR;
          w_row_n   = '0;
        end
      end
      ST_ADDR:    w_state_n = ST_CAPTURE;
      ST_CAPTURE: begin
        w_state_n = ST_EMIT;
        w_col_n   = '0;
      end
      ST_EMIT: begin
        // A lost cycle leaves col unchanged so the same character retries.
        if (w_dump_win) begin
          if (r_col == 3'd7) begin
            if (r_row == LAST_ROW) begin
              w_state_n = ST_DONE;
            end else begin
              w_state_n = ST_ADDR;
              w_row_n   = r_row + 5'd1;
            end
          end else begin
            w_col_n = r_col + 3'd1;
          end
        end
      end
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_shadow    <= '0;
      r_cpu_gnt   <= 1'b0;
      r_dump_done <= 1'b0;
      r_vga_we    <= 1'b0;
      r_vga_addr  <= '0;
      r_vga_data  <= '0;
    end else begin
      r_state     <= w_state_n;
      r_row       <= w_row_n;
      r_col       <= w_col_n;
      r_cpu_gnt   <= w_cpu_win;
      r_dump_done <= (r_state == ST_DONE);
      r_vga_we    <= w_cpu_win | w_dump_win;
      if (r_state == ST_CAPTURE) begin
        r_shadow <= i_dbg_reg_data[31:0];
      end
      if (w_cpu_win) begin
        r_vga_addr <= i_cpu_addr;
        r_vga_data <= i_cpu_data;
      end else if (w_dump_win) begin
        r_vga_addr <= w_dump_addr;
        r_vga_data <= w_dump_data;
      end
    end
  end

`ifdef VGA_WRITE_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio_dump <= 1'b0;
    end else if (w_cpu_elig && w_dump_req) begin
      r_prio_dump <= w_cpu_win;
    end
  end
`endif

  assign o_cpu_gnt      = r_cpu_gnt;
  assign o_dump_done    = r_dump_done;
  assign o_dump_busy    = (r_state == ST_ADDR) || (r_state == ST_CAPTURE) ||
                          (r_state == ST_EMIT);
  assign o_dbg_reg_addr = r_row;
  assign o_vga_we       = r_vga_we;
  assign o_vga_addr     = r_vga_addr;
  assign o_vga_data     = r_vga_data;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Self-checking bench for vga_write_arbiter: register dump, CPU stores,
// contention with random CPU traffic, mid-dump reset and repeated dump_start.
module tb_vga_write_arbiter;
  localparam int WS   = 32;
  localparam int ROWS = 32;
  localparam int COLS = 80;
`ifdef VGA_WRITE_ARB_ROUND_ROBIN_EN
  localparam int MAX_LAT = 2;
`else
  localparam int MAX_LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0;
  logic [12:0]   cpu_addr = '0;
  logic [WS-1:0] cpu_data = '0;
  logic          cpu_gnt;
  logic          dump_start = 1'b0;
  logic          dump_busy, dump_done;
  logic [4:0]    dbg_reg_addr;
  logic [WS-1:0] dbg_reg_data;
  logic          vga_we;
  logic [12:0]   vga_addr;
  logic [WS-1:0] vga_data;

  logic [WS-1:0] regs [32];
  assign dbg_reg_data = regs[dbg_reg_addr];

  vga_write_arbiter #(.WORD_SIZE(WS), .DUMP_ROWS(ROWS), .COLS(COLS)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cpu_req     (cpu_req),
    .i_cpu_addr    (cpu_addr),
    .i_cpu_data    (cpu_data),
    .o_cpu_gnt     (cpu_gnt),
    .i_dump_start  (dump_start),
    .o_dump_busy   (dump_busy),
    .o_dump_done   (dump_done),
    .o_dbg_reg_addr(dbg_reg_addr),
    .i_dbg_reg_data(dbg_reg_data),
    .o_vga_we      (vga_we),
    .o_vga_addr    (vga_addr),
    .o_vga_data    (vga_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0]   addr;
    logic [WS-1:0] data;
    logic          gnt;
  } wr_t;

  wr_t wr_q[$];
  int  done_cnt = 0;
  int  n_checks = 0;
  int  n_fail   = 0;

  // Observe the write port mid-cycle.
  always @(negedge clk) begin
    if (rst && vga_we) wr_q.push_back('{addr: vga_addr, data: vga_data, gnt: cpu_gnt});
    if (rst && dump_done) done_cnt++;
  end

  // Reference: hex character for column c of word w.
  function automatic logic [WS-1:0] exp_char(input logic [WS-1:0] w, input int c);
    int         nib;
    logic [7:0] a;
    nib = int'((w >> (4 * (7 - c))) & 32'hF);
    a   = (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
    exp_char        = '0;
    exp_char[31:0]  = {a, 24'hFFFFFF};
  endfunction

  function automatic logic [12:0] exp_addr(input int r, input int c);
    exp_addr = 13'((r * COLS + c) % 8192);
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 dump_start = 1'b1;
    @(posedge clk); #1 dump_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (vga_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", vga_we); end
    n_checks++; if (vga_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", vga_addr); end
    n_checks++; if (vga_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", vga_data); end
    n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", cpu_gnt); end
    n_checks++; if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", dump_busy); end
    n_checks++; if (dump_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", dump_done); end
    n_checks++; if (dbg_reg_addr !== 5'd0) begin n_fail++; $display("FAIL reset_dbg_addr: got %h expected 0", dbg_reg_addr); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (vga_we !== 1'b0 || dump_busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: we=%b busy=%b expected 0 0", vga_we, dump_busy);
    end
  endtask

  task automatic test_dump_basic();
    int    n;
    string s;
    s = "1234ABCD";
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[1] = 32'h1234ABCD;
    wr_q.delete();
    done_cnt = 0;
    pulse_start();
    n = 0;
    while (n < 2000) begin
      @(posedge clk); n++; #1;
      if (n == 1) begin
        n_checks++; if (dump_busy !== 1'b1) begin n_fail++; $display("FAIL dump_busy: got %b expected 1", dump_busy); end
      end
      if (dump_done) break;
    end
    n_checks++; if (n != 321) begin n_fail++; $display("FAIL dump_latency: got %0d cycles expected 321", n); end
    @(posedge clk); #1;
    n_checks++; if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: done=%b busy=%b expected 0 0", dump_done, dump_busy);
    end
    n_checks++; if (wr_q.size() != 256) begin n_fail++; $display("FAIL dump_count: got %0d expected 256", wr_q.size()); end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (r * 8 + c < wr_q.size()) begin
          n_checks++;
          if (wr_q[r*8+c].addr !== exp_addr(r, c) || wr_q[r*8+c].data !== exp_char(regs[r], c) ||
              wr_q[r*8+c].gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL dump_char r%0d c%0d: got %h/%h expected %h/%h", r, c,
                     wr_q[r*8+c].addr, wr_q[r*8+c].data, exp_addr(r, c), exp_char(regs[r], c));
          end
        end
      end
    end
    for (int c = 0; c < 8; c++) begin
      if (8 + c < wr_q.size()) begin
        n_checks++;
        if (wr_q[8+c].addr !== 13'(80 + c) || wr_q[8+c].data[31:24] !== 8'(s[c])) begin
          n_fail++;
          $display("FAIL row1_text c%0d: got %h/%h expected %h/%h", c, wr_q[8+c].addr,
                   wr_q[8+c].data[31:24], 13'(80 + c), 8'(s[c]));
        end
      end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_cpu_single();
    int lat;
    wr_q.delete();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 13'h100; cpu_data = 32'h41FFFFFF;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); lat++; #1;
      if (cpu_gnt) break;
    end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL cpu_latency: got %0d expected 1", lat); end
    @(posedge clk); #1;   // request still high through the grant cycle
    n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL cpu_gnt_pulse: got %b expected 0", cpu_gnt); end
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL cpu_write_count: got %0d expected 1", wr_q.size()); end
    if (wr_q.size() > 0) begin
      n_checks++;
      if (wr_q[0].addr !== 13'h100 || wr_q[0].data !== 32'h41FFFFFF || wr_q[0].gnt !== 1'b1) begin
        n_fail++; $display("FAIL cpu_write: got %h/%h/%b expected 100/41ffffff/1",
                           wr_q[0].addr, wr_q[0].data, wr_q[0].gnt);
      end
    end
  endtask

  task automatic test_cpu_during_dump();
    wr_t cpu_exp[$];
    wr_t cpu_got[$];
    wr_t dmp_got[$];
    int  n, lat, req_cnt;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    wr_q.delete();
    done_cnt = 0;
    req_cnt  = 0;
    lat      = 0;
    n        = 0;
    pulse_start();
    while (n < 6000 && (done_cnt == 0 || cpu_req)) begin
      @(posedge clk); n++; #1;
      if (cpu_req) begin
        lat++;
        if (cpu_gnt) begin
          n_checks++;
          if (lat < 1 || lat > MAX_LAT) begin
            n_fail++; $display("FAIL cpu_grant_latency: got %0d expected 1..%0d", lat, MAX_LAT);
          end
          cpu_req = 1'b0;
        end
      end else if (!cpu_gnt && done_cnt == 0 && req_cnt < 60 && $urandom_range(3) != 0) begin
        cpu_req  = 1'b1;
        cpu_addr = 13'($urandom);
        cpu_data = $urandom;
        cpu_exp.push_back('{addr: cpu_addr, data: cpu_data, gnt: 1'b1});
        req_cnt++;
        lat = 0;
      end
    end
    cpu_req = 1'b0;
    n_checks++; if (n >= 6000) begin n_fail++; $display("FAIL contention_timeout: got %0d cycles expected <6000", n); end
    repeat (3) @(posedge clk);
    foreach (wr_q[i]) begin
      if (wr_q[i].gnt) cpu_got.push_back(wr_q[i]);
      else dmp_got.push_back(wr_q[i]);
    end
    n_checks++; if (cpu_got.size() != cpu_exp.size()) begin
      n_fail++; $display("FAIL cpu_write_total: got %0d expected %0d", cpu_got.size(), cpu_exp.size());
    end
    for (int i = 0; i < cpu_exp.size() && i < cpu_got.size(); i++) begin
      n_checks++;
      if (cpu_got[i] !== cpu_exp[i]) begin
        n_fail++; $display("FAIL cpu_write_%0d: got %h/%h expected %h/%h", i, cpu_got[i].addr,
                           cpu_got[i].data, cpu_exp[i].addr, cpu_exp[i].data);
      end
    end
    n_checks++; if (dmp_got.size() != 256) begin n_fail++; $display("FAIL stall_dump_count: got %0d expected 256", dmp_got.size()); end
    for (int k = 0; k < 256 && k < dmp_got.size(); k++) begin
      n_checks++;
      if (dmp_got[k].addr !== exp_addr(k / 8, k % 8) || dmp_got[k].data !== exp_char(regs[k/8], k % 8)) begin
        n_fail++; $display("FAIL stall_char_%0d: got %h/%h expected %h/%h", k, dmp_got[k].addr,
                           dmp_got[k].data, exp_addr(k / 8, k % 8), exp_char(regs[k/8], k % 8));
      end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid_dump();
    int n;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    wr_q.delete();
    done_cnt = 0;
    pulse_start();
    n = 0;
    // 43 characters written means row 5 col 3 is next.
    while (n < 1000 && wr_q.size() < 43) begin
      @(negedge clk); n++; #1;
    end
    rst = 1'b0;
    #1;
    n_checks++; if (vga_we !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs: we=%b busy=%b done=%b expected 0 0 0", vga_we, dump_busy, dump_done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (wr_q.size() != 43) begin n_fail++; $display("FAIL mid_reset_writes: got %0d expected 43", wr_q.size()); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL mid_reset_done: got %0d expected 0", done_cnt); end
    wr_q.delete();
    pulse_start();
    n = 0;
    while (n < 2000 && done_cnt == 0) begin
      @(posedge clk); n++;
    end
    repeat (2) @(posedge clk);
    n_checks++; if (wr_q.size() != 256) begin n_fail++; $display("FAIL restart_count: got %0d expected 256", wr_q.size()); end
    if (wr_q.size() > 0) begin
      n_checks++;
      if (wr_q[0].addr !== 13'd0 || wr_q[0].data !== exp_char(regs[0], 0)) begin
        n_fail++; $display("FAIL restart_first: got %h/%h expected 0/%h", wr_q[0].addr, wr_q[0].data,
                           exp_char(regs[0], 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    wr_q.delete();
    done_cnt = 0;
    pulse_start();
    n = 0;
    while (n < 2000 && done_cnt == 0) begin
      @(posedge clk); n++; #1;
      dump_start = (n == 50 || n == 200 || n == 319);
    end
    dump_start = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (wr_q.size() != 256) begin n_fail++; $display("FAIL b2b_write_count: got %0d expected 256", wr_q.size()); end
    n_checks++; if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b expected 0", dump_busy); end
    if (wr_q.size() == 256) begin
      n_checks++;
      if (wr_q[255].addr !== exp_addr(31, 7) || wr_q[255].data !== exp_char(regs[31], 7)) begin
        n_fail++; $display("FAIL b2b_last: got %h/%h expected %h/%h", wr_q[255].addr, wr_q[255].data,
                           exp_addr(31, 7), exp_char(regs[31], 7));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    test_reset();
    test_dump_basic();
    test_cpu_single();
    test_cpu_during_dump();
    test_reset_mid_dump();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_write_arbiter.md
VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 32, sets the width of the text-buffer data word and the debug register word.
REQ-002 Parameter DUMP_ROWS, default 32, sets the number of registers dumped (rows 0..DUMP_ROWS-1); legal range 1..32.
REQ-003 Parameter COLS, default 80, sets the characters per text row used in address generation.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 cpu_req  in  1  CPU store request to the text buffer; held high until cpu_gnt is seen.
REQ-007 cpu_addr  in  13  CPU target character address.
REQ-008 cpu_data  in  WORD_SIZE  CPU store data.
REQ-009 cpu_gnt  out  1  one-cycle pulse; the CPU write has been issued.
REQ-010 dump_start  in  1  pulse; requests a full register dump.
REQ-011 dump_busy  out  1  high from dump acceptance until dump_done.
REQ-012 dump_done  out  1  one-cycle pulse after the last dump character is issued.
REQ-013 dbg_reg_addr  out  5  register index presented to the register file debug port.
REQ-014 dbg_reg_data  in  WORD_SIZE  register file debug read data; combinational from dbg_reg_addr.
REQ-015 vga_we  out  1  text-buffer write enable, one cycle per character.
REQ-016 vga_addr  out  13  text-buffer write address.
REQ-017 vga_data  out  WORD_SIZE  text-buffer write data.

Function
REQ-018 The dump FSM SHALL have states IDLE, ADDR, CAPTURE, EMIT and DONE.
REQ-019 In IDLE, dump_start high moves the FSM to ADDR with row=0; dump_start in any other state SHALL be ignored.
REQ-020 ADDR drives dbg_reg_addr=row; the next edge moves to CAPTURE.
REQ-021 CAPTURE latches dbg_reg_data into a shadow word, sets col=0, and moves to EMIT.
REQ-022 EMIT requests one character per cycle: nibble = shadow[(7-col)*4+3:(7-col)*4], most-significant nibble first.
REQ-023 Hex encoding SHALL be 0-9 -> 0x30-0x39 and A-F -> 0x41-0x46.
REQ-024 Character data SHALL be {ascii[7:0], 24'hFFFFFF}; for WORD_SIZE above 32, the upper bits are zero.
REQ-025 Dump address SHALL be row*COLS+col, truncated to 13 bits.
REQ-026 An EMIT cycle that loses arbitration SHALL hold col and retry next cycle; no character is skipped or duplicated.
REQ-027 On a won EMIT with col=7, the FSM SHALL move to ADDR with row+1, or to DONE if row=DUMP_ROWS-1.
REQ-028 DONE pulses dump_done for one cycle and returns to IDLE.
REQ-029 dump_busy SHALL be high in ADDR, CAPTURE and EMIT.
REQ-030 Arbitration is decided each cycle between cpu_req and an EMIT request; the winner's address and data SHALL be registered to vga_addr/vga_data with vga_we=1 on the next edge (latency 1).
REQ-031 cpu_gnt SHALL assert in the same cycle as the vga_we carrying the CPU write.
REQ-032 cpu_req SHALL NOT be accepted in a cycle where cpu_gnt is high, so that a held request is never written twice.
REQ-033 With no winner, vga_we=0; vga_addr and vga_data hold their last values.

Reset
REQ-034 On rst low: FSM=IDLE, row=0, col=0, shadow=0, dbg_reg_addr=0, vga_we=0, vga_addr=0, vga_data=0, cpu_gnt=0, dump_busy=0, dump_done=0, priority pointer=CPU.
REQ-035 Reset mid-dump SHALL abort the dump with no further writes and no dump_done pulse.

Configuration
REQ-036 Macro VGA_WRITE_ARB_ROUND_ROBIN_EN defined: on a simultaneous CPU/dump request, the requester that did not win the last contested cycle wins (pointer starts at CPU).
REQ-037 Macro VGA_WRITE_ARB_ROUND_ROBIN_EN undefined: the CPU always wins, and the dump stalls while cpu_req is eligible.

Verification
REQ-038 Registers x1=0x1234ABCD, others 0, dump_start, no CPU traffic -> 256 writes; row 1 cols 0..7 at addr 80..87 carry "1234ABCD" (0x31..0x44); dump_done arrives 32*(1+1+8)+1 cycles after start.
REQ-039 cpu_req held with addr=0x100, data=0x41FFFFFF while idle -> vga_we one cycle at 0x100, cpu_gnt one pulse, no second write even though req stays high one extra cycle.
REQ-040 Fixed priority, cpu_req continuously re-asserted during EMIT -> dump stalls with col held; the dump completes after the CPU stops, with all 256 characters correct.
REQ-041 Round-robin, both requesters continuous -> vga_we alternates CPU/dump on contested cycles, starting with the CPU.
REQ-042 rst low at row 5, col 3 -> vga_we=0 from the reset onward, dump_busy=0, and no dump_done pulse; a new dump_start restarts at row 0.
REQ-043 dump_start pulsed again while busy -> ignored; exactly one dump_done pulse.
